// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the serialiser.
// The line output is a register that only moves on bit boundaries.
module uart_tx #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int BAUD_DIV   = (CLK_HZ + BAUD / 2) / BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_25mhz,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          ftdi_rxd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BAUD_DIV + 1);

  localparam logic [AW:0]   FULL_C   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DIV_LAST = CW'(BAUD_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   count_q;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          rxd_q, rxd_d;

  logic push;
  logic pop;
  logic tick;
  logic has_data;

  assign has_data   = (count_q != '0);
  assign tick       = (baud_q == DIV_LAST);
  assign tx_ready   = (count_q < FULL_C);
  assign push       = tx_valid & tx_ready;
  assign fifo_count = count_q;
  assign ftdi_rxd   = rxd_q;
  assign tx_busy    = (state_q != S_IDLE) | has_data;

  // Pop loads the shift register so later FIFO writes never touch the frame.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    rxd_d   = rxd_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (has_data) begin
          pop     = 1'b1;
          sh_d    = mem_q[rd_q];
          rxd_d   = 1'b0;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          baud_d  = '0;
          bit_d   = '0;
          rxd_d   = sh_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tick) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            rxd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
            sh_d  = {1'b0, sh_q[7:1]};
            rxd_d = sh_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          baud_d = '0;
          if (has_data) begin
            pop     = 1'b1;
            sh_d    = mem_q[rd_q];
            rxd_d   = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (!rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      rxd_q   <= 1'b1;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      rxd_q   <= rxd_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (rst && push) mem_q[wr_q] <= tx_data;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed scenarios plus random bytes,
// every frame decoded by a cycle-accurate line receiver model.
module tb_uart_tx;

  localparam int DIV   = 217;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ftdi_rxd;
  logic       tx_busy;
  logic [2:0] fifo_count;

  uart_tx #(
    .CLK_HZ(25000000),
    .BAUD(115200),
    .BAUD_DIV(DIV),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_25mhz(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ftdi_rxd(ftdi_rxd),
    .tx_busy(tx_busy),
    .fifo_count(fifo_count)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         start_q[$];

  // Line receiver: every bit must hold one level for exactly DIV clocks.
  bit         rx_active = 1'b0;
  int         rx_cyc = 0;
  logic       rx_cur = 1'b1;
  bit         rx_glitch = 1'b0;
  logic [7:0] rx_byte = 8'h00;

  always @(negedge clk) begin
    int bi;
    int ph;
    if (!rst) begin
      rx_active = 1'b0;
    end else begin
      if (!rx_active && ftdi_rxd === 1'b0) begin
        rx_active = 1'b1;
        rx_cyc = 0;
        start_q.push_back(cyc);
      end
      if (rx_active) begin
        bi = rx_cyc / DIV;
        ph = rx_cyc % DIV;
        if (ph == 0) begin
          rx_cur = ftdi_rxd;
          rx_glitch = 1'b0;
        end else if (ftdi_rxd !== rx_cur) begin
          rx_glitch = 1'b1;
        end
        if (ph == DIV - 1) begin
          checks++;
          if (rx_glitch || (bi == 0 && rx_cur !== 1'b0) ||
              (bi == 9 && rx_cur !== 1'b1) || rx_cur === 1'bx) begin
            errors++;
            $display("FAIL rx_bit%0d at cycle %0d: level %b glitch %0d",
                     bi, cyc, rx_cur, rx_glitch);
          end
          if (bi >= 1 && bi <= 8) rx_byte[bi-1] = rx_cur;
          if (bi == 9) begin
            rx_q.push_back(rx_byte);
            rx_active = 1'b0;
          end
        end
        rx_cyc++;
      end
    end
  end

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    tx_data = b;
    tx_valid = 1'b1;
    while (!acc && n < 10000) begin
      acc = tx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    tx_valid = 1'b0;
    if (acc) begin
      exp_q.push_back(b);
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout byte %h: tx_ready %b, required 1", b, tx_ready);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((tx_busy !== 1'b0 || rx_active) && n < 40000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 40000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: tx_busy %b, required 0", tx_busy);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic compare_rx(input string name);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: received %0d bytes, required %0d",
               name, rx_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s_byte%0d: received %h, required %h",
                   name, i, rx_q[i], exp_q[i]);
        end
      end
    end
    rx_q.delete();
    exp_q.delete();
    start_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'hA7;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (ftdi_rxd !== 1'b1 || tx_ready !== 1'b1 ||
        tx_busy !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: rxd %b ready %b busy %b count %0d, required 1 1 0 0",
               ftdi_rxd, tx_ready, tx_busy, fifo_count);
    end
    tx_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_single();
    int e;
    tx_data = 8'h55;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    e = cyc;
    exp_q.push_back(8'h55);
    checks++;
    if (fifo_count !== 3'd1 || ftdi_rxd !== 1'b1) begin
      errors++;
      $display("FAIL first_accept: count %0d rxd %b, required 1 1", fifo_count, ftdi_rxd);
    end
    wait_until(e + 1);
    checks++;
    if (ftdi_rxd !== 1'b0 || fifo_count !== 3'd0 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: rxd %b count %0d busy %b, required 0 0 1",
               ftdi_rxd, fifo_count, tx_busy);
    end
    wait_until(e + DIV);
    checks++;
    if (ftdi_rxd !== 1'b0) begin
      errors++;
      $display("FAIL start_last_clock: rxd %b, required 0", ftdi_rxd);
    end
    wait_until(e + DIV + 1);
    checks++;
    if (ftdi_rxd !== 1'b1) begin
      errors++;
      $display("FAIL data_bit0: rxd %b, required 1", ftdi_rxd);
    end
    wait_until(e + 1 + 2 * DIV);
    checks++;
    if (ftdi_rxd !== 1'b0) begin
      errors++;
      $display("FAIL data_bit1: rxd %b, required 0", ftdi_rxd);
    end
    wait_until(e + FRAME);
    checks++;
    if (tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_stop: busy %b, required 1", tx_busy);
    end
    wait_until(e + FRAME + 1);
    checks++;
    if (tx_busy !== 1'b0 || ftdi_rxd !== 1'b1) begin
      errors++;
      $display("FAIL busy_fall: busy %b rxd %b, required 0 1", tx_busy, ftdi_rxd);
    end
    wait_idle();
    compare_rx("single");
  endtask

  task automatic test_back_to_back();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hA5);
    wait_idle();
    checks++;
    if (start_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_frames: got %0d frames, required 3", start_q.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (start_q[i] - start_q[i-1] != FRAME) begin
          errors++;
          $display("FAIL b2b_gap%0d: spacing %0d, required %0d",
                   i, start_q[i] - start_q[i-1], FRAME);
        end
      end
    end
    compare_rx("b2b");
  endtask

  task automatic test_fifo_full();
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    checks++;
    if (fifo_count !== 3'd4 || tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_flag: count %0d ready %b, required 4 0", fifo_count, tx_ready);
    end
    tx_data = 8'h06;
    tx_valid = 1'b1;
    repeat (50) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL full_stall: count %0d, required 4", fifo_count);
    end
    send_byte(8'h06);
    wait_idle();
    compare_rx("full");
  endtask

  task automatic test_push_on_pop();
    int e;
    int p1;
    int p2;
    int p3;
    logic [7:0] x;
    logic [7:0] y;
    x = 8'($urandom);
    y = 8'($urandom);
    send_byte(8'($urandom));
    e = cyc;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    checks++;
    if (cyc != e + 4 || fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL pp_fill: count %0d at cycle %0d, required 4 at %0d",
               fifo_count, cyc, e + 4);
    end
    p1 = e + 1 + FRAME;
    p2 = p1 + FRAME;
    p3 = p2 + FRAME;
    wait_until(p1 - 1);
    tx_data = x;
    tx_valid = 1'b1;
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL pp_ready_full: ready %b, required 0", tx_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (fifo_count !== 3'd3) begin
      errors++;
      $display("FAIL pp_pop_edge: count %0d, required 3", fifo_count);
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    exp_q.push_back(x);
    checks++;
    if (fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL pp_refill: count %0d, required 4", fifo_count);
    end
    wait_until(p2);
    checks++;
    if (fifo_count !== 3'd3) begin
      errors++;
      $display("FAIL pp_pop2: count %0d, required 3", fifo_count);
    end
    wait_until(p3 - 1);
    tx_data = y;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    exp_q.push_back(y);
    checks++;
    if (fifo_count !== 3'd3) begin
      errors++;
      $display("FAIL pp_simul: count %0d, required 3", fifo_count);
    end
    wait_idle();
    compare_rx("pushpop");
  endtask

  task automatic test_reset_mid();
    int e;
    int r;
    send_byte(8'h3C);
    e = cyc;
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    r = e + 1 + 4 * DIV + 100;
    wait_until(r - 1);
    checks++;
    if (ftdi_rxd !== 1'b1 || fifo_count !== 3'd2) begin
      errors++;
      $display("FAIL mid_bit3: rxd %b count %0d, required 1 2", ftdi_rxd, fifo_count);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ftdi_rxd !== 1'b1 || fifo_count !== 3'd0 ||
        tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_abort: rxd %b count %0d busy %b ready %b, required 1 0 0 1",
               ftdi_rxd, fifo_count, tx_busy, tx_ready);
    end
    rst = 1'b1;
    exp_q.delete();
    send_byte(8'h81);
    wait_idle();
    compare_rx("after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      send_byte(8'($urandom));
    end
    wait_idle();
    compare_rx("random");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_push_on_pop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
